// File: rtl/if_stage_if.sv
// IF <-> ID pipeline handshake: ID back-pressure, branch redirect, and the
// fetched-instruction bus handed from IF to ID.
interface if_stage_if;
  logic        id_allow_in;
  logic [32:0] id_to_if_branch_bus;       // {taken, target[31:0]}
  logic [64:0] if_to_id_instruction_bus;  // {valid, program_count[31:0], instruction[31:0]}

  modport master (
    input  id_allow_in,
    input  id_to_if_branch_bus,
    output if_to_id_instruction_bus
  );

  modport slave (
    output id_allow_in,
    output id_to_if_branch_bus,
    input  if_to_id_instruction_bus
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, single-cycle SRAM fetch, delay-slot
// aware branch redirect, and a one-entry skid buffer for ID back-pressure.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
  input  logic        clock,
  input  logic        reset,
  if_stage_if.master  id_bus,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_wen,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata
);

  typedef enum logic {
    IDLE,
    PENDING
  } state_e;

  state_e      state_q;
  logic [31:0] if_pc_q;
  logic        if_valid_q;
  logic [31:0] pend_target_q;
  logic [31:0] inst_buf_q;
  logic        inst_buf_valid_q;

  logic [31:0] pc_d;
  logic [31:0] instruction;
  logic [31:0] branch_target;
  logic        branch_taken;
  logic        branch_fire;
  logic        if_allow_in;

  always_comb begin
    branch_taken  = id_bus.id_to_if_branch_bus[32];
    branch_target = id_bus.id_to_if_branch_bus[31:0];
    if_allow_in   = !if_valid_q || id_bus.id_allow_in;
    // ID keeps asserting taken while it holds the branch; only the first cycle may redirect.
    branch_fire   = branch_taken && (state_q == IDLE) && if_valid_q;
    if (state_q == PENDING) begin
      pc_d = pend_target_q;
    end else if (branch_fire) begin
      pc_d = branch_target;
    end else begin
      pc_d = if_pc_q + 32'd4;
    end
    instruction = inst_buf_valid_q ? inst_buf_q : inst_sram_rdata;
  end

  assign inst_sram_en    = if_allow_in && !reset;
  assign inst_sram_addr  = pc_d;
  assign inst_sram_wen   = '0;
  assign inst_sram_wdata = '0;

  assign id_bus.if_to_id_instruction_bus = {if_valid_q, if_pc_q, instruction};

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= IDLE;
      if_pc_q          <= RESET_PC - 32'd4;
      if_valid_q       <= 1'b0;
      pend_target_q    <= '0;
      inst_buf_q       <= '0;
      inst_buf_valid_q <= 1'b0;
    end else begin
      if (if_allow_in) begin
        if_pc_q          <= pc_d;
        if_valid_q       <= 1'b1;
        inst_buf_valid_q <= 1'b0;
      end else if (!inst_buf_valid_q) begin
        // Stalled with a valid word: rdata is only good this first cycle, so keep it.
        inst_buf_q       <= inst_sram_rdata;
        inst_buf_valid_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (branch_fire && !if_allow_in) begin
            pend_target_q <= branch_target;
            state_q       <= PENDING;
          end
        end
        PENDING: begin
          if (if_allow_in) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Randomized scoreboard bench for if_stage: an ID/SRAM model predicts the
// program-order PC stream, a monitor checks every IF->ID transfer against it.
module tb_if_stage;
  localparam logic [31:0] RESET_PC = 32'hbfc0_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;

  if_stage_if bus ();

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clock           (clock),
    .reset           (reset),
    .id_bus          (bus),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata)
  );

  always #5 clock = ~clock;

  // Instruction memory contents: a unique word per address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  // One-cycle-latency SRAM; data is garbage after a cycle without enable.
  always @(posedge clock) begin
    if (inst_sram_en) inst_sram_rdata <= mem_word(inst_sram_addr);
    else              inst_sram_rdata <= $urandom;
  end

  int unsigned checks = 0;
  int unsigned passes = 0;
  int unsigned xfers  = 0;
  logic        xfer   = 1'b0;
  logic [31:0] exp_q[$];

  task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Monitor: pops the expected program-order PC on every IF->ID transfer.
  initial begin
    logic        post_reset;
    logic        valid_exp;
    logic        prev_stall;
    logic [64:0] prev_bus;
    logic [64:0] cur;
    logic [31:0] e;
    post_reset = 1'b0;
    valid_exp  = 1'b0;
    prev_stall = 1'b0;
    prev_bus   = '0;
    forever begin
      @(negedge clock);
      cur = bus.if_to_id_instruction_bus;
      chk("sram_write_tied", {29'b0, inst_sram_wen, inst_sram_wdata}, 65'd0);
      if (reset) begin
        chk("en_during_reset", {64'b0, inst_sram_en}, 65'd0);
        post_reset = 1'b1;
        valid_exp  = 1'b0;
        prev_stall = 1'b0;
      end else if (post_reset) begin
        chk("valid_after_reset", {64'b0, cur[64]}, 65'd0);
        chk("first_fetch", {32'b0, inst_sram_en, inst_sram_addr}, {32'b0, 1'b1, RESET_PC});
        post_reset = 1'b0;
        valid_exp  = 1'b1;
        prev_stall = 1'b0;
      end else begin
        chk("bus_valid", {64'b0, cur[64]}, {64'b0, valid_exp});
        chk("fetch_en", {64'b0, inst_sram_en}, {64'b0, bus.id_allow_in});
        if (prev_stall) chk("stall_hold", cur, prev_bus);
        if (cur[64] && bus.id_allow_in) begin
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL xfer_unexpected: got pc %h expected no transfer", cur[63:32]);
          end else begin
            e = exp_q.pop_front();
            chk("xfer_pc_inst", {1'b0, cur[63:0]}, {1'b0, e, mem_word(e)});
          end
          xfer = 1'b1;
          xfers++;
        end
        prev_stall = cur[64] && !bus.id_allow_in;
        prev_bus   = cur;
      end
    end
  end

  // Driver + ID model: decides branches for instructions entering ID and
  // rewrites the expected program order (delay slot, then target).
  initial begin
    logic        id_valid;
    logic        id_branch;
    logic        next_delay;
    logic [31:0] id_target;
    id_valid   = 1'b0;
    id_branch  = 1'b0;
    next_delay = 1'b0;
    id_target  = '0;
    reset = 1'b1;
    bus.id_allow_in = 1'b0;
    bus.id_to_if_branch_bus = '0;
    exp_q.push_back(RESET_PC);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    while (exp_q.size() < 4) exp_q.push_back(exp_q[$] + 32'd4);
    bus.id_allow_in = 1'b1;

    for (int c = 0; c < 4000; c++) begin
      @(posedge clock);
      #1;
      if (xfer) begin
        xfer      = 1'b0;
        id_valid  = 1'b1;
        id_branch = 1'b0;
        if (!next_delay && $urandom_range(3) == 0) begin
          id_branch  = 1'b1;
          next_delay = 1'b1;
          if ($urandom_range(1) == 0) id_target = $urandom & 32'hffff_fffc;
          else id_target = 32'hffff_fff0 + 32'($urandom_range(3)) * 32'd4;
          while (exp_q.size() > 1) void'(exp_q.pop_back());
          exp_q.push_back(id_target);
        end else begin
          next_delay = 1'b0;
        end
      end
      if (reset) begin
        reset = 1'b0;
      end else if ((id_branch && !bus.id_allow_in && $urandom_range(7) == 0) ||
                   $urandom_range(499) == 0) begin
        reset      = 1'b1;
        id_valid   = 1'b0;
        id_branch  = 1'b0;
        next_delay = 1'b0;
        exp_q.delete();
        exp_q.push_back(RESET_PC);
      end
      while (exp_q.size() < 4) exp_q.push_back(exp_q[$] + 32'd4);
      bus.id_allow_in = ($urandom_range(9) < 7);
      bus.id_to_if_branch_bus = {id_valid && id_branch, id_target};
    end

    chk("progress", {64'b0, xfers >= 32'd1000}, 65'd1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
